// File: rtl/reg_file32.sv
// ---------------------------------------------------------------------------
// reg_file32 : 32-entry x 32-bit general-purpose register file for the lab
// CPU datapath. Two combinational read ports, one synchronous write port.
// Register 0 is hardwired to zero. With BYPASS=1, a write that is being
// presented this cycle is forwarded to any read port addressing the same
// register, so the reading stage sees the write-back value before the edge.
//
// Ports:
//   clk        in   single clock, all state updates on the rising edge
//   rst        in   synchronous active-high reset, clears every register
//   R_Addr_A   in   read address, port A (feeds ALU operand A)
//   R_Addr_B   in   read address, port B (feeds register leg of ALU-B mux)
//   W_Addr     in   write address
//   W_Data     in   write data
//   Write_Reg  in   write enable
//   R_Data_A   out  read data, port A (combinational)
//   R_Data_B   out  read data, port B (combinational)
// ---------------------------------------------------------------------------
module reg_file32 #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] R_Addr_A,
  input  logic [ADDR_W-1:0] R_Addr_B,
  input  logic [ADDR_W-1:0] W_Addr,
  input  logic [DATA_W-1:0] W_Data,
  input  logic              Write_Reg,
  output logic [DATA_W-1:0] R_Data_A,
  output logic [DATA_W-1:0] R_Data_B
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];

  // A write only takes effect when not in reset and not aimed at r0; the
  // same qualified condition gates the bypass so r0 and the reset cycle
  // never forward data.
  logic wr_en;
  assign wr_en = Write_Reg && !rst && (W_Addr != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[W_Addr] <= W_Data;
    end
  end

  // Address 0 is decoded explicitly rather than relying on regs[0] holding
  // zero, so r0 reads 0 even before the first reset edge.
  always_comb begin
    R_Data_A = regs[R_Addr_A];
    if (R_Addr_A == '0) begin
      R_Data_A = '0;
    end else if (BYPASS && wr_en && (W_Addr == R_Addr_A)) begin
      R_Data_A = W_Data;
    end
  end

  always_comb begin
    R_Data_B = regs[R_Addr_B];
    if (R_Addr_B == '0) begin
      R_Data_B = '0;
    end else if (BYPASS && wr_en && (W_Addr == R_Addr_B)) begin
      R_Data_B = W_Data;
    end
  end

endmodule

// File: tb/tb_reg_file32.sv
// ---------------------------------------------------------------------------
// tb_reg_file32 : self-checking bench for reg_file32. Two instances share all
// inputs, one built with BYPASS=1 and one with BYPASS=0, so every stimulus
// cycle exercises both read behaviours. Inputs change on the falling edge and
// outputs are sampled 1 time unit later, well before the next rising edge.
// ---------------------------------------------------------------------------
module tb_reg_file32;

  logic        clk;
  logic        rst;
  logic [4:0]  R_Addr_A, R_Addr_B, W_Addr;
  logic [31:0] W_Data;
  logic        Write_Reg;
  logic [31:0] a_byp, b_byp, a_nob, b_nob;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference contents of the register file (architectural view).
  logic [31:0] mem [32];

  reg_file32 #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) u_byp (
    .clk(clk), .rst(rst), .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B),
    .W_Addr(W_Addr), .W_Data(W_Data), .Write_Reg(Write_Reg),
    .R_Data_A(a_byp), .R_Data_B(b_byp)
  );

  reg_file32 #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) u_nob (
    .clk(clk), .rst(rst), .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B),
    .W_Addr(W_Addr), .W_Data(W_Data), .Write_Reg(Write_Reg),
    .R_Data_A(a_nob), .R_Data_B(b_nob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] a1;   // expected port A, BYPASS=1
    logic [31:0] b1;   // expected port B, BYPASS=1
    logic [31:0] a0;   // expected port A, BYPASS=0
    logic [31:0] b0;   // expected port B, BYPASS=0
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present inputs for one cycle and let the combinational outputs settle.
  task automatic drive(input logic r, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] ra, input logic [4:0] rb);
    @(negedge clk);
    rst = r; Write_Reg = we; W_Addr = wa; W_Data = wd;
    R_Addr_A = ra; R_Addr_B = rb;
    #1;
  endtask

  // Advance through the rising edge and apply the architectural update.
  task automatic commit();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    end else if (Write_Reg && W_Addr != 5'd0) begin
      mem[W_Addr] = W_Data;
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [4:0] addr, input bit byp);
    if (addr == 5'd0) return 32'h0;
    if (byp && Write_Reg && !rst && W_Addr == addr) return W_Data;
    return mem[addr];
  endfunction

  task automatic chk_model(input string tag);
    chk({tag, "_A_byp"}, a_byp, model_rd(R_Addr_A, 1'b1));
    chk({tag, "_B_byp"}, b_byp, model_rd(R_Addr_B, 1'b1));
    chk({tag, "_A_nob"}, a_nob, model_rd(R_Addr_A, 1'b0));
    chk({tag, "_B_nob"}, b_nob, model_rd(R_Addr_B, 1'b0));
  endtask

  function automatic logic [31:0] sweep_val(input int a);
    if (a == 0) return 32'h0;
    return 32'(a * 32'h0101_0101);
  endfunction

  initial begin
    rst = 1'b1; Write_Reg = 1'b0; W_Addr = '0; W_Data = '0;
    R_Addr_A = '0; R_Addr_B = '0;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;

    // Bring the file to a known state.
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0); commit();
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0); commit();

    //              rst   we    wa     wd             ra     rb     a1             b1             a0             b0
    vecs[0]  = '{1'b0, 1'b0, 5'd0,  32'h0,         5'd0,  5'd5,  32'h0,         32'h0,         32'h0,         32'h0};
    vecs[1]  = '{1'b0, 1'b1, 5'd7,  32'hDEAD_BEEF, 5'd7,  5'd7,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0,         32'h0};
    vecs[2]  = '{1'b0, 1'b0, 5'd0,  32'h0,         5'd7,  5'd0,  32'hDEAD_BEEF, 32'h0,         32'hDEAD_BEEF, 32'h0};
    vecs[3]  = '{1'b0, 1'b1, 5'd12, 32'h1234_5678, 5'd12, 5'd12, 32'h1234_5678, 32'h1234_5678, 32'h0,         32'h0};
    vecs[4]  = '{1'b0, 1'b0, 5'd0,  32'h0,         5'd12, 5'd7,  32'h1234_5678, 32'hDEAD_BEEF, 32'h1234_5678, 32'hDEAD_BEEF};
    vecs[5]  = '{1'b0, 1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd0,  32'h0,         32'h0,         32'h0,         32'h0};
    vecs[6]  = '{1'b0, 1'b0, 5'd0,  32'h0,         5'd0,  5'd12, 32'h0,         32'h1234_5678, 32'h0,         32'h1234_5678};
    vecs[7]  = '{1'b1, 1'b1, 5'd3,  32'h5555_AAAA, 5'd3,  5'd7,  32'h0,         32'hDEAD_BEEF, 32'h0,         32'hDEAD_BEEF};
    vecs[8]  = '{1'b0, 1'b0, 5'd0,  32'h0,         5'd3,  5'd7,  32'h0,         32'h0,         32'h0,         32'h0};
    vecs[9]  = '{1'b0, 1'b1, 5'd3,  32'h0000_0001, 5'd3,  5'd12, 32'h0000_0001, 32'h0,         32'h0,         32'h0};
    vecs[10] = '{1'b0, 1'b1, 5'd3,  32'h0000_0002, 5'd3,  5'd3,  32'h0000_0002, 32'h0000_0002, 32'h0000_0001, 32'h0000_0001};
    vecs[11] = '{1'b0, 1'b0, 5'd0,  32'h0,         5'd3,  5'd3,  32'h0000_0002, 32'h0000_0002, 32'h0000_0002, 32'h0000_0002};

    for (int v = 0; v < 12; v++) begin
      drive(vecs[v].rst, vecs[v].we, vecs[v].wa, vecs[v].wd, vecs[v].ra, vecs[v].rb);
      chk($sformatf("vec%0d_A_byp", v), a_byp, vecs[v].a1);
      chk($sformatf("vec%0d_B_byp", v), b_byp, vecs[v].b1);
      chk($sformatf("vec%0d_A_nob", v), a_nob, vecs[v].a0);
      chk($sformatf("vec%0d_B_nob", v), b_nob, vecs[v].b0);
      commit();
    end

    // Reset clear: preload r1..r31, one reset cycle, then read everything.
    for (int i = 1; i < 32; i++) begin
      drive(1'b0, 1'b1, 5'(i), 32'hA5A5_0000 + 32'(i), 5'd0, 5'd0); commit();
    end
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0); commit();
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
      chk($sformatf("rstclr%0d_A_byp", i), a_byp, 32'h0);
      chk($sformatf("rstclr%0d_B_byp", i), b_byp, 32'h0);
      chk($sformatf("rstclr%0d_A_nob", i), a_nob, 32'h0);
      chk($sformatf("rstclr%0d_B_nob", i), b_nob, 32'h0);
      commit();
    end

    // Full sweep: consecutive writes, then read pairs (i, 31-i).
    for (int i = 1; i < 32; i++) begin
      drive(1'b0, 1'b1, 5'(i), sweep_val(i), 5'd0, 5'd0); commit();
    end
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
      chk($sformatf("sweep%0d_A_byp", i), a_byp, sweep_val(i));
      chk($sformatf("sweep%0d_B_byp", i), b_byp, sweep_val(31 - i));
      chk($sformatf("sweep%0d_A_nob", i), a_nob, sweep_val(i));
      chk($sformatf("sweep%0d_B_nob", i), b_nob, sweep_val(31 - i));
      commit();
    end

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 31)), $urandom,
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      chk_model($sformatf("rnd%0d", n));
      commit();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/reg_file32.md
Name: reg_file32

Overview:
- 32-entry x 32-bit general-purpose register file for the lab CPU datapath.
- Sits directly upstream of the 32-bit 2:1 operand/write-back multiplexers.
  - Port A feeds ALU operand A.
  - Port B feeds the X0 leg of the ALU-B operand mux, which selects register vs immediate.
- Two combinational read ports and one synchronous write port.
- Register 0 is hardwired to zero.
- Optional write-to-read bypass lets a same-cycle write-back be seen by the reading stage.

Parameters:
- DATA_W, 32, data width of each register and of the read/write data ports.
- ADDR_W, 5, address width; depth = 2**ADDR_W = 32 entries.
- BYPASS, 1, 1 = read ports forward W_Data on a same-cycle address match; 0 = reads return stored contents only.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- R_Addr_A  input  ADDR_W  read address, port A.
- R_Addr_B  input  ADDR_W  read address, port B.
- W_Addr  input  ADDR_W  write address.
- W_Data  input  DATA_W  write data.
- Write_Reg  input  1  write enable.
- R_Data_A  output  DATA_W  read data, port A (combinational).
- R_Data_B  output  DATA_W  read data, port B (combinational).

Behaviour:
- Storage: array regs[0..31] of DATA_W bits. regs[0] is never written and always reads 0.
- Reset: on a rising clk edge with rst=1, all 32 registers clear to 0. Consequences:
  - Both read ports output 0 for every address from the edge onward, until a write occurs.
  - rst has priority over Write_Reg: a write presented in the reset cycle is discarded.
- Write:
  - On a rising clk edge with rst=0, Write_Reg=1 and W_Addr!=0: regs[W_Addr] <= W_Data.
  - Write_Reg=1 with W_Addr=0 has no effect.
  - Write_Reg=0 leaves all registers unchanged.
  - Latency is one edge: the stored value is visible on a read port from the cycle after the edge.
- Read:
  - Purely combinational, zero-cycle latency.
  - R_Data_X = 0 if R_Addr_X==0; otherwise regs[R_Addr_X], subject to the bypass rule below.
  - X-free: outputs never go X or Z for any valid address.
- Bypass (BYPASS=1):
  - If Write_Reg=1, rst=0, W_Addr!=0 and W_Addr==R_Addr_X, then R_Data_X = W_Data in the same cycle, before the edge.
  - Applies independently to port A and port B; both may bypass simultaneously.
  - Suppressed when rst=1 and when W_Addr=0.
- Bypass (BYPASS=0): reads return the pre-edge stored value; the new value appears the next cycle.
- Simultaneous events:
  - Both ports may read the same address in the same cycle with identical results.
  - Read and write of the same address in one cycle follow the bypass rule.
  - Consecutive-cycle writes to the same address: last write wins.
- Reset mid-operation: asserting rst in any cycle clears the whole file at that edge, regardless of the write in flight. Deasserting rst allows normal writes on the next edge.
- No handshake: writes are accepted unconditionally every cycle Write_Reg=1. There are no stall or ready outputs.

Test Plan:
- Reset clear:
  - Stimulus: preload regs 1..31 with 32'hA5A5_0000+i, assert rst for one cycle, then read all addresses on both ports.
  - Required: every read = 32'h0000_0000.
- Write/read latency (BYPASS=0):
  - Stimulus: write 32'hDEAD_BEEF to r7 while R_Addr_A=7.
  - Required: R_Data_A = old value (0) before the edge; 32'hDEAD_BEEF in the next cycle.
- Bypass (BYPASS=1):
  - Stimulus: Write_Reg=1, W_Addr=12, W_Data=32'h1234_5678, R_Addr_A=R_Addr_B=12.
  - Required: both ports show 32'h1234_5678 in the same cycle; r12 holds it afterwards.
- Zero register:
  - Stimulus: write 32'hFFFF_FFFF to r0 with R_Addr_A=0, BYPASS=1.
  - Required: R_Data_A = 0 in that cycle and in all following cycles.
- Reset priority:
  - Stimulus: rst=1 and Write_Reg=1, W_Addr=3, W_Data=32'h5555_AAAA in the same cycle; then rst=0 and read r3.
  - Required: r3 = 0; no bypass is visible during the reset cycle.
- Full sweep:
  - Stimulus: write i*32'h0101_0101 to each r1..r31 on consecutive edges, then read pairs (i, 31-i).
  - Required: each port returns its own register's value exactly, including at addresses 1 and 31.
